ps2_scan_receiver: RTL and testbench
====================================

# ps2_scan_receiver

Parametrised PS/2 keyboard receiver. It runs entirely in the system clock domain and oversamples `ps2Clk`/`ps2Data` through synchronisers. It decodes 11-bit frames with odd-parity and stop-bit checking plus an inactivity watchdog, and folds E0/F0 prefixes into per-event flags. Decoded key events are buffered in a FIFO with a valid/ready interface, which feeds the display/speed-control logic downstream.

## Interface
- `CLK_HZ`, 100000000: system clock frequency.
- `TIMEOUT_US`, 2000: max gap between ps2Clk falling edges inside a frame.
- `FIFO_DEPTH`, 8: event FIFO entries, power of two, ≥2.
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ps2Clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2Data`  in  1  raw PS/2 data, asynchronous.
- `evtReady`  in  1  consumer accepts the head event.
- `evtValid`  out  1  FIFO non-empty.
- `evtCode`  out  8  scan code of the head event.
- `evtExt`  out  1  head event was preceded by E0.
- `evtBreak`  out  1  head event was preceded by F0 (key release).
- `fifoLevel`  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- `parityErr`  out  1  one-cycle pulse when a frame is dropped for parity.
- `frameErr`  out  1  one-cycle pulse on bad stop bit or timeout.
- `overflow`  out  1  one-cycle pulse when an event is dropped because the FIFO is full.

## Operation
- Input conditioning: 2-FF synchroniser on each of `ps2Clk` and `ps2Data`, then a registered previous value of the clock. A falling edge ("fe") is previous=1 and current=0. Data is sampled from the synchronised `ps2Data` in the fe cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Transitions occur only on fe or on timeout.
  - IDLE: on fe with data=0, go to DATA; bit count=0 and shift register cleared. On fe with data=1 (glitch), stay in IDLE; no error.
  - DATA: shift LSB-first into `byte[7:0]`. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP:
    - data=1 and XOR(byte, parity)=1: byte accepted; go to IDLE.
    - data=1 and XOR=0: `parityErr`; byte discarded; prefix flags cleared; go to IDLE.
    - data=0: `frameErr`; byte discarded; prefix flags cleared; go to IDLE.
- Watchdog: counter of `TIMEOUT_CYC = CLK_HZ/1_000_000*TIMEOUT_US` cycles. It clears on every fe and is held at 0 in IDLE. If it reaches TIMEOUT_CYC-1 outside IDLE: `frameErr`, go to IDLE, partial byte discarded, prefix flags cleared.
- Prefix folding on an accepted byte:
  - 8'hE0 sets `extPend`.
  - 8'hF0 sets `brkPend`.
  - Any other byte (including E1) is pushed as {extPend, brkPend, byte}, and both flags clear in the same cycle.
  - Prefix bytes are never pushed.
- FIFO: show-ahead. The head is visible on `evt*` while `evtValid`=1. Pop occurs when `evtValid && evtReady`.
- Full and push without pop: event dropped, `overflow` pulses, FIFO contents unchanged, flags still clear.
- Full and push with pop in the same cycle: both happen; level unchanged.
- Empty: `evtReady` is ignored. `evt*` data outputs hold 0 when empty.
- Reset (any time, including mid-frame): FSM to IDLE, counters/flags/FIFO cleared, synchronisers to 1 (bus-idle value).
  - Output reset values: `evtValid`=0, `evtCode`=0, `evtExt`=0, `evtBreak`=0, `fifoLevel`=0, all error pulses 0.

## Timing
- Synchroniser latency is 2 cycles; fe detection is 3 cycles after a raw pin edge.
- Stop-bit fe detected in cycle N: error pulse or push occurs in cycle N. `evtValid` rises and `fifoLevel` increments in N+1.
- Pop at the cycle-N edge: the next head (or `evtValid`=0) is visible in N+1.
- Error/overflow pulses are exactly 1 cycle wide and registered.
- Nominal PS/2 clock (10–16.7 kHz) gives ≥3000 system cycles per bit at 100 MHz; no minimum is imposed beyond 4 cycles per PS/2 clock phase.

## Structure
- Shared package/include `ps2_defs`:
  - constants PS2_PFX_EXT=8'hE0 and PS2_PFX_BRK=8'hF0;
  - FSM state encodings (2 bits);
  - event word layout {ext, brk, code[7:0]} of 10 bits.
- Sub-module `event_fifo`: parametrised WIDTH/DEPTH synchronous FIFO with show-ahead output, level output, and push/pop/full/empty. It is reused later for other input queues.
- Top level contains: synchronisers, fe detect, FSM, watchdog, prefix logic, and the `event_fifo` instance.

## Test plan
- Frame 0x1C, parity 0, stop 1, `evtReady`=0 → one event: code=8'h1C, ext=0, brk=0, `fifoLevel`=1, `evtValid` asserted the cycle after the stop fe.
- Byte sequence E0, F0, 75 → single event {ext=1, brk=1, code=8'h75}. A following byte 75 → {0, 0, 8'h75}.
- Frame 0x1C with parity 1 → `parityErr` pulse, FIFO unchanged. Also: E0 then a bad frame then 74 → event {0, 0, 74}.
- Stop bit 0 → `frameErr`. Frame stalled after 4 data bits for >TIMEOUT_CYC → `frameErr` at the timeout, FSM in IDLE, next clean 0x2B frame → event 0x2B.
- 9 codes with `FIFO_DEPTH`=8 and no pops → level 8, one `overflow` pulse, head still the first code. Push and pop in the same cycle while full → level stays 8.
- `rst_n` asserted mid-frame (after 5 bits) → all outputs 0 immediately. A complete frame 0x21 after release → event 0x21 only.

Source files
------------

// File: rtl/ps2_defs.sv
// Shared PS/2 receiver definitions: prefix codes, FSM encoding and event word layout.
package ps2_defs;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int unsigned PS2_EVT_W = $bits(ps2_evt_t);

endpackage

// File: rtl/event_fifo.sv
// Synchronous show-ahead FIFO; head, valid, level and flags are all registered.
module event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [LW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Next head is precomputed so the show-ahead output can be a flop.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    rd_nxt   = rd_ptr + AW'(pop_ok);
    cnt_nxt  = level + LW'(push_ok) - LW'(pop_ok);
    head_nxt = '0;
    if (cnt_nxt != '0) begin
      if (push_ok && (rd_nxt == wr_ptr)) head_nxt = push_data;
      else                               head_nxt = mem[rd_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_nxt;
      level    <= cnt_nxt;
      rd_data  <= head_nxt;
      rd_valid <= (cnt_nxt != '0);
      full     <= (cnt_nxt == LW'(DEPTH));
      empty    <= (cnt_nxt == '0);
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: oversampled frame decode, watchdog, E0/F0 folding, event FIFO.
module ps2_scan_receiver
  import ps2_defs::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2Clk,
  input  logic                        ps2Data,
  input  logic                        evtReady,
  output logic                        evtValid,
  output logic [7:0]                  evtCode,
  output logic                        evtExt,
  output logic                        evtBreak,
  output logic [$clog2(FIFO_DEPTH):0] fifoLevel,
  output logic                        parityErr,
  output logic                        frameErr,
  output logic                        overflow
);

  localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned WD_W        = $clog2(TIMEOUT_CYC + 1);

  logic            clk_s1, clk_s2, clk_prev;
  logic            dat_s1, dat_s2;
  logic            fe_c;
  ps2_state_e      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [WD_W-1:0] wd;
  logic            ext_pend, brk_pend;
  logic            push_q;
  ps2_evt_t        push_evt;
  ps2_evt_t        head;
  logic            fifo_full, fifo_empty, fifo_pop;

  // Synchronisers idle high to match the released bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2Clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2Data;
      dat_s2   <= dat_s1;
    end
  end

  assign fe_c = clk_prev & ~clk_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      wd        <= '0;
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      push_q    <= 1'b0;
      push_evt  <= '0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      push_q    <= 1'b0;
      if (state == ST_IDLE) begin
        wd <= '0;
        if (fe_c && !dat_s2) begin
          state   <= ST_DATA;
          bit_cnt <= '0;
          shreg   <= '0;
        end
      end else if (fe_c) begin
        wd <= '0;
        unique case (state)
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= dat_s2;
            state   <= ST_STOP;
          end
          default: begin
            state <= ST_IDLE;
            if (!dat_s2) begin
              frameErr <= 1'b1;
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end else if (!(^{shreg, par_bit})) begin
              parityErr <= 1'b1;
              ext_pend  <= 1'b0;
              brk_pend  <= 1'b0;
            end else if (shreg == PS2_PFX_EXT) begin
              ext_pend <= 1'b1;
            end else if (shreg == PS2_PFX_BRK) begin
              brk_pend <= 1'b1;
            end else begin
              push_q   <= 1'b1;
              push_evt <= '{ext: ext_pend, brk: brk_pend, code: shreg};
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
            end
          end
        endcase
      end else if (wd == WD_W'(TIMEOUT_CYC - 1)) begin
        // Stalled frame: abandon the partial byte and any pending prefix.
        frameErr <= 1'b1;
        state    <= ST_IDLE;
        wd       <= '0;
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else begin
        wd <= wd + WD_W'(1);
      end
    end
  end

  assign fifo_pop = evtReady & ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow <= 1'b0;
    else        overflow <= push_q & fifo_full & ~fifo_pop;
  end

  event_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_evt),
    .pop       (fifo_pop),
    .rd_data   (head),
    .rd_valid  (evtValid),
    .level     (fifoLevel),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evtCode  = head.code;
  assign evtExt   = head.ext;
  assign evtBreak = head.brk;

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: table-driven frames plus multi-cycle corner sequences.
module tb_ps2_scan_receiver;

  localparam int unsigned CLK_HZ      = 10000000;
  localparam int unsigned TIMEOUT_US  = 20;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned TIMEOUT_CYC = 200;
  localparam int          HALF        = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic       evtReady = 1'b0;
  logic       evtValid;
  logic [7:0] evtCode;
  logic       evtExt;
  logic       evtBreak;
  logic [3:0] fifoLevel;
  logic       parityErr;
  logic       frameErr;
  logic       overflow;

  ps2_scan_receiver #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2Clk    (ps2Clk),
    .ps2Data   (ps2Data),
    .evtReady  (evtReady),
    .evtValid  (evtValid),
    .evtCode   (evtCode),
    .evtExt    (evtExt),
    .evtBreak  (evtBreak),
    .fifoLevel (fifoLevel),
    .parityErr (parityErr),
    .frameErr  (frameErr),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } exp_evt_t;

  typedef struct {
    logic [7:0] code;
    logic       par_bad;
    logic       stop;
    logic       exp_push;
    logic       exp_ext;
    logic       exp_brk;
    int         exp_perr;
    int         exp_ferr;
  } vec_t;

  exp_evt_t exp_q[$];
  vec_t     tbl[15];
  int       n_checks = 0;
  int       n_errors = 0;
  int       perr_cnt = 0;
  int       ferr_cnt = 0;
  int       ovf_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_evt(input logic ext, input logic brk, input logic [7:0] code);
    exp_evt_t e;
    e.ext  = ext;
    e.brk  = brk;
    e.code = code;
    exp_q.push_back(e);
  endtask

  // Pulse counters and scoreboard compare on every accepted head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (parityErr) perr_cnt++;
      if (frameErr)  ferr_cnt++;
      if (overflow)  ovf_cnt++;
      if (evtValid && evtReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_evt", 32'({evtExt, evtBreak, evtCode}), 32'hFFFF_FFFF);
        end else begin
          exp_evt_t e;
          e = exp_q.pop_front();
          check("evt", 32'({evtExt, evtBreak, evtCode}), 32'(e));
        end
      end
    end
  end

  // mode 1: check evtValid latency after stop fall; mode 2: pop in the cycle the event is pushed.
  task automatic send_frame(input logic [7:0] code, input logic par_bad, input logic stop,
                            input int nbits, input int mode);
    logic [10:0] bits;
    bits = {stop, (~^code) ^ par_bad, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2Data = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2Clk = 1'b0;
      if (i == 10 && mode == 1) begin
        repeat (3) @(posedge clk);
        #1 check("valid_before_push", 32'(evtValid), 32'd0);
        @(posedge clk);
        #1 check("valid_after_push", 32'(evtValid), 32'd1);
        repeat (HALF - 4) @(posedge clk);
      end else if (i == 10 && mode == 2) begin
        repeat (3) @(posedge clk);
        #1 evtReady = 1'b1;
        @(posedge clk);
        #1 evtReady = 1'b0;
        repeat (HALF - 4) @(posedge clk);
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic drain();
    evtReady = 1'b1;
    for (int i = 0; i < 300 && (exp_q.size() != 0 || evtValid); i++) @(posedge clk);
    #1;
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_level", 32'(fifoLevel), 32'd0);
  endtask

  initial begin
    int p0, f0, o0;

    tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[2]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[4]  = '{8'h75, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[5]  = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[6]  = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[7]  = '{8'h2A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1};
    tbl[8]  = '{8'h74, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
    tbl[9]  = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[10] = '{8'hE1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};
    tbl[11] = '{8'hE0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[12] = '{8'h6B, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
    tbl[13] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[14] = '{8'h6B, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0};

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(evtValid), 32'd0);
    check("rst_head", 32'({evtExt, evtBreak, evtCode}), 32'd0);
    check("rst_level", 32'(fifoLevel), 32'd0);
    check("rst_pulses", 32'({parityErr, frameErr, overflow}), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single frame held in the FIFO, with push latency.
    evtReady = 1'b0;
    expect_evt(1'b0, 1'b0, 8'h1C);
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1);
    #1;
    check("lat_code", 32'(evtCode), 32'h1C);
    check("lat_flags", 32'({evtExt, evtBreak}), 32'd0);
    check("lat_level", 32'(fifoLevel), 32'd1);
    drain();

    // Table of frames with the consumer always ready.
    foreach (tbl[k]) begin
      if (tbl[k].exp_push) expect_evt(tbl[k].exp_ext, tbl[k].exp_brk, tbl[k].code);
      p0 = perr_cnt;
      f0 = ferr_cnt;
      send_frame(tbl[k].code, tbl[k].par_bad, tbl[k].stop, 11, 0);
      repeat (6) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_perr", k), 32'(perr_cnt - p0), 32'(tbl[k].exp_perr));
      check($sformatf("tbl%0d_ferr", k), 32'(ferr_cnt - f0), 32'(tbl[k].exp_ferr));
    end
    drain();

    // Stall after four data bits; watchdog must abort the frame.
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b1, 5, 0);
    repeat (TIMEOUT_CYC + 50) @(posedge clk);
    #1;
    check("timeout_ferr", 32'(ferr_cnt - f0), 32'd1);
    check("timeout_valid", 32'(evtValid), 32'd0);
    expect_evt(1'b0, 1'b0, 8'h2B);
    send_frame(8'h2B, 1'b0, 1'b1, 11, 0);
    drain();

    // Fill past capacity, then push and pop together while full.
    evtReady = 1'b0;
    o0 = ovf_cnt;
    for (int k = 0; k < 9; k++) begin
      if (k < 8) expect_evt(1'b0, 1'b0, 8'(8'h10 + k));
      send_frame(8'(8'h10 + k), 1'b0, 1'b1, 11, 0);
    end
    #1;
    check("full_level", 32'(fifoLevel), 32'd8);
    check("full_ovf", 32'(ovf_cnt - o0), 32'd1);
    check("full_head", 32'(evtCode), 32'h10);
    expect_evt(1'b0, 1'b0, 8'h19);
    send_frame(8'h19, 1'b0, 1'b1, 11, 2);
    #1;
    check("pushpop_level", 32'(fifoLevel), 32'd8);
    check("pushpop_ovf", 32'(ovf_cnt - o0), 32'd1);
    check("pushpop_head", 32'(evtCode), 32'h11);
    drain();

    // Reset in the middle of a frame with a stale event buffered.
    evtReady = 1'b0;
    send_frame(8'h33, 1'b0, 1'b1, 11, 0);
    #1 check("pre_rst_valid", 32'(evtValid), 32'd1);
    send_frame(8'h44, 1'b0, 1'b1, 6, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(evtValid), 32'd0);
    check("midrst_head", 32'({evtExt, evtBreak, evtCode}), 32'd0);
    check("midrst_level", 32'(fifoLevel), 32'd0);
    ps2Clk  = 1'b1;
    ps2Data = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    evtReady = 1'b1;
    expect_evt(1'b0, 1'b0, 8'h21);
    send_frame(8'h21, 1'b0, 1'b1, 11, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
